// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end for the synchronous 128x8 program ROM: owns the PC,
// hides the ROM read latency and presents sized instructions over valid/ready.
// Optional stall counter enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int         ROM_DEPTH = 128,
  parameter logic [7:0] RESET_PC  = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  rom_address,
  input  logic [7:0]  rom_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [7:0]  instr_operand,
  output logic        instr_len2,
  output logic [7:0]  instr_pc,
  input  logic        branch_take,
  input  logic [7:0]  branch_target,
  output logic [15:0] stall_cycles
);

  localparam logic [7:0] ADDR_MASK = 8'(ROM_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_ISSUE    = 2'd0,
    ST_CAPT_OP  = 2'd1,
    ST_CAPT_OPR = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] r_fetch_ptr;
  logic       r_valid;
  logic [7:0] r_opcode;
  logic [7:0] r_operand;
  logic       r_len2;
  logic [7:0] r_instr_pc;

  state_t     w_state_nx;
  logic [7:0] w_pc_nx;
  logic [7:0] w_fetch_ptr_nx;
  logic       w_valid_nx;
  logic [7:0] w_opcode_nx;
  logic [7:0] w_operand_nx;
  logic       w_len2_nx;
  logic [7:0] w_instr_pc_nx;
  logic [7:0] w_pc_plus1;
  logic [7:0] w_pc_step;
  logic       w_data_len2;

  // Only the ALU group (high nibble 4) is a single byte; everything else carries an operand.
  function automatic logic is_len2(input logic [7:0] op);
    return (op[7:4] != 4'h4);
  endfunction

  assign w_pc_plus1  = (r_pc + 8'd1) & ADDR_MASK;
  assign w_pc_step   = (r_pc + (r_len2 ? 8'd2 : 8'd1)) & ADDR_MASK;
  assign w_data_len2 = is_len2(rom_data);

  // Next-state and next-output computation; branch overrides every state.
  always_comb begin
    w_state_nx     = r_state;
    w_pc_nx        = r_pc;
    w_fetch_ptr_nx = r_fetch_ptr;
    w_valid_nx     = r_valid;
    w_opcode_nx    = r_opcode;
    w_operand_nx   = r_operand;
    w_len2_nx      = r_len2;
    w_instr_pc_nx  = r_instr_pc;
    if (branch_take) begin
      w_state_nx     = ST_ISSUE;
      w_pc_nx        = branch_target & ADDR_MASK;
      w_fetch_ptr_nx = branch_target & ADDR_MASK;
      w_valid_nx     = 1'b0;
    end else begin
      case (r_state)
        ST_ISSUE: begin
          w_fetch_ptr_nx = w_pc_plus1;
          w_state_nx     = ST_CAPT_OP;
        end
        ST_CAPT_OP: begin
          w_opcode_nx   = rom_data;
          w_len2_nx     = w_data_len2;
          w_operand_nx  = 8'h00;
          w_instr_pc_nx = r_pc;
          if (w_data_len2) begin
            w_state_nx = ST_CAPT_OPR;
            w_valid_nx = 1'b0;
          end else begin
            w_state_nx = ST_HOLD;
            w_valid_nx = 1'b1;
          end
        end
        ST_CAPT_OPR: begin
          w_operand_nx = rom_data;
          w_state_nx   = ST_HOLD;
          w_valid_nx   = 1'b1;
        end
        ST_HOLD: begin
          if (instr_ready) begin
            w_pc_nx        = w_pc_step;
            w_fetch_ptr_nx = w_pc_step;
            w_state_nx     = ST_ISSUE;
            w_valid_nx     = 1'b0;
          end else begin
            w_state_nx = ST_HOLD;
            w_valid_nx = 1'b1;
          end
        end
        default: begin
          w_state_nx     = ST_ISSUE;
          w_fetch_ptr_nx = r_pc;
          w_valid_nx     = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset beats branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_ISSUE;
      r_pc        <= RESET_PC;
      r_fetch_ptr <= RESET_PC;
      r_valid     <= 1'b0;
      r_opcode    <= 8'h00;
      r_operand   <= 8'h00;
      r_len2      <= 1'b0;
      r_instr_pc  <= 8'h00;
    end else begin
      r_state     <= w_state_nx;
      r_pc        <= w_pc_nx;
      r_fetch_ptr <= w_fetch_ptr_nx;
      r_valid     <= w_valid_nx;
      r_opcode    <= w_opcode_nx;
      r_operand   <= w_operand_nx;
      r_len2      <= w_len2_nx;
      r_instr_pc  <= w_instr_pc_nx;
    end
  end

  assign rom_address   = r_fetch_ptr;
  assign instr_valid   = r_valid;
  assign instr_opcode  = r_opcode;
  assign instr_operand = r_operand;
  assign instr_len2    = r_len2;
  assign instr_pc      = r_instr_pc;

`ifdef IFU_PERF_CNT_EN
  logic [15:0] r_stall;

  // Saturating count of cycles where a presented instruction is refused.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= 16'h0000;
    end else if (r_valid && !instr_ready && !branch_take && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end else begin
      r_stall <= r_stall;
    end
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed table, corner sequences and a
// randomized run against an instruction-level reference model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rom_address;
  logic [7:0]  rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_operand;
  logic        instr_len2;
  logic [7:0]  instr_pc;
  logic        branch_take;
  logic [7:0]  branch_target;
  logic [15:0] stall_cycles;

  logic [7:0] mem [128];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Behavioural synchronous ROM: one-cycle registered read.
  always @(posedge clk) rom_data <= mem[rom_address[6:0]];

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .rom_address(rom_address), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_operand(instr_operand), .instr_len2(instr_len2), .instr_pc(instr_pc),
    .branch_take(branch_take), .branch_target(branch_target), .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic [7:0] opc;
    logic [7:0] opr;
    logic       len2;
    logic [7:0] pc;
    int         lat;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    branch_take = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", instr_valid, 1);
  endtask

  task automatic do_branch(input logic [7:0] tgt);
    branch_take = 1'b1;
    branch_target = tgt;
    @(negedge clk);
    branch_take = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[0] = 8'h86; mem[1] = 8'hAA; mem[2] = 8'h96; mem[3] = 8'hE0;
    mem[4] = 8'h20; mem[5] = 8'h00; mem[6] = 8'h42; mem[7] = 8'h46;
  endtask

  task automatic chk_reset_vals();
    chk("rst_rom_address", rom_address, 8'h00);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_opcode", instr_opcode, 8'h00);
    chk("rst_operand", instr_operand, 8'h00);
    chk("rst_len2", instr_len2, 1'b0);
    chk("rst_pc", instr_pc, 8'h00);
    chk("rst_stall", stall_cycles, 16'h0000);
  endtask

  function automatic int lat_of(input logic [7:0] pc);
    return (mem[pc[6:0]][7:4] == 4'h4) ? 2 : 3;
  endfunction

  function automatic logic len2_of(input logic [7:0] pc);
    return (mem[pc[6:0]][7:4] != 4'h4);
  endfunction

  initial begin
    int n;
    logic [7:0]  m_pc;
    int          m_wait;
    logic [15:0] m_stall;
    logic        exp_valid, rdy, br, rst;
    logic [7:0]  tgt, nxt;
    logic [15:0] exp_stall;

    reset = 1'b1; instr_ready = 1'b0; branch_take = 1'b0; branch_target = 8'h00;
    tbl[0] = '{opc: 8'h86, opr: 8'hAA, len2: 1'b1, pc: 8'h00, lat: 3};
    tbl[1] = '{opc: 8'h96, opr: 8'hE0, len2: 1'b1, pc: 8'h02, lat: 3};
    tbl[2] = '{opc: 8'h20, opr: 8'h00, len2: 1'b1, pc: 8'h04, lat: 3};
    tbl[3] = '{opc: 8'h42, opr: 8'h00, len2: 1'b0, pc: 8'h06, lat: 2};
    tbl[4] = '{opc: 8'h46, opr: 8'h00, len2: 1'b0, pc: 8'h07, lat: 2};
    load_prog();
    @(negedge clk);

    // Table: sequential stream with ready held high.
    apply_reset();
    chk_reset_vals();
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(n);
      chk("tbl_latency", n, tbl[i].lat);
      chk("tbl_opcode", instr_opcode, tbl[i].opc);
      chk("tbl_operand", instr_operand, tbl[i].opr);
      chk("tbl_len2", instr_len2, tbl[i].len2);
      chk("tbl_pc", instr_pc, tbl[i].pc);
      @(negedge clk);
      chk("tbl_valid_drop", instr_valid, 1'b0);
    end

    // Back-pressure for 10 cycles.
    instr_ready = 1'b0;
    apply_reset();
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_opcode", instr_opcode, 8'h86);
      chk("stall_operand", instr_operand, 8'hAA);
      chk("stall_pc", instr_pc, 8'h00);
    end
`ifdef IFU_PERF_CNT_EN
    exp_stall = 16'd10;
`else
    exp_stall = 16'd0;
`endif
    chk("stall_count", stall_cycles, exp_stall);
    instr_ready = 1'b1;
    @(negedge clk);
    chk("stall_valid_drop", instr_valid, 1'b0);
    chk("stall_count_hold", stall_cycles, exp_stall);

    // Branch during CAPT_OPR of the instruction at 0x00.
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    chk("br_not_valid", instr_valid, 1'b0);
    do_branch(8'h04);
    wait_valid(n);
    chk("br_latency", n, 3);
    chk("br_pc", instr_pc, 8'h04);
    chk("br_opcode", instr_opcode, 8'h20);

    // Wrap at the top of the ROM and masked branch targets.
    mem[127] = 8'h23; mem[0] = 8'h5A; mem[1] = 8'h42; mem[5] = 8'h31; mem[6] = 8'h77;
    do_branch(8'hFF);
    wait_valid(n);
    chk("wrap_pc", instr_pc, 8'h7F);
    chk("wrap_opcode", instr_opcode, 8'h23);
    chk("wrap_operand", instr_operand, 8'h5A);
    @(negedge clk);
    wait_valid(n);
    chk("wrap_next_pc", instr_pc, 8'h01);
    chk("wrap_next_len2", instr_len2, 1'b0);
    chk("wrap_next_lat", n, 2);
    do_branch(8'h85);
    wait_valid(n);
    chk("mask_pc", instr_pc, 8'h05);
    chk("mask_opcode", instr_opcode, 8'h31);
    chk("mask_operand", instr_operand, 8'h77);

    // Reset, accept and branch on the same HOLD edge.
    load_prog();
    apply_reset();
    wait_valid(n);
    reset = 1'b1; instr_ready = 1'b1; branch_take = 1'b1; branch_target = 8'h10;
    @(negedge clk);
    reset = 1'b0; branch_take = 1'b0;
    chk_reset_vals();
    wait_valid(n);
    chk("rst_refetch_pc", instr_pc, 8'h00);
    chk("rst_refetch_opcode", instr_opcode, 8'h86);

    // Randomized run against an instruction-level model.
    for (int i = 0; i < 128; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? {4'h4, 4'($urandom)} : 8'($urandom);
    instr_ready = 1'b0;
    apply_reset();
    m_pc = 8'h00; m_wait = lat_of(m_pc); m_stall = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      exp_valid = (m_wait == 0);
      chk("rnd_valid", instr_valid, exp_valid);
      if (exp_valid) begin
        chk("rnd_pc", instr_pc, m_pc);
        chk("rnd_opcode", instr_opcode, mem[m_pc[6:0]]);
        chk("rnd_len2", instr_len2, len2_of(m_pc));
        nxt = (m_pc + 8'd1) & 8'h7F;
        chk("rnd_operand", instr_operand, len2_of(m_pc) ? mem[nxt[6:0]] : 8'h00);
      end
      chk("rnd_stall", stall_cycles, m_stall);
      rst = ($urandom_range(0, 199) == 0);
      br  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      tgt = 8'($urandom);
      reset = rst; branch_take = br; instr_ready = rdy; branch_target = tgt;
      if (rst) begin
        m_pc = 8'h00; m_wait = lat_of(m_pc); m_stall = 16'h0000;
      end else begin
`ifdef IFU_PERF_CNT_EN
        if (exp_valid && !rdy && !br && m_stall != 16'hFFFF) m_stall++;
`endif
        if (br) begin
          m_pc = tgt & 8'h7F; m_wait = lat_of(m_pc);
        end else if (exp_valid && rdy) begin
          m_pc = (m_pc + (len2_of(m_pc) ? 8'd2 : 8'd1)) & 8'h7F; m_wait = lat_of(m_pc);
        end else if (m_wait > 0) begin
          m_wait--;
        end
      end
      @(negedge clk);
    end
    reset = 1'b0; branch_take = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front-end that drives the synchronous 128x8 program ROM and assembles opcode/operand bytes into whole instructions for the decode/control unit. It owns the program counter (PC) and compensates for the ROM's one-cycle registered read latency. It sizes each instruction from its opcode and presents it over a valid/ready handshake. It accepts branch redirects from the control unit and sits between `rom_128x8_sync` and the CPU control FSM.

## Interface
Parameters:
- `ROM_DEPTH`, 128: number of ROM words. The PC wraps modulo this value, which must be a power of two ≤ 256.
- `RESET_PC`, 8'h00: PC value loaded on reset.

Ports:
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: synchronous, active-high reset.
- `rom_address` output 8: address to the ROM `address` port. The ROM samples it at each `clk` rising edge.
- `rom_data` input 8: from the ROM `data_out` port. It holds ROM[address sampled at previous edge].
- `instr_valid` output 1: a complete instruction is presented.
- `instr_ready` input 1: decode accepts the instruction this cycle.
- `instr_opcode` output 8: opcode byte.
- `instr_operand` output 8: operand byte. It reads 8'h00 for 1-byte instructions.
- `instr_len2` output 1: 1 means the instruction has an operand byte.
- `instr_pc` output 8: ROM address of the opcode byte.
- `branch_take` input 1: redirect request.
- `branch_target` input 8: redirect address.
- `stall_cycles` output 16: performance counter. See Configuration.

## Operation
- Length rule: `opcode[7:4] == 4'h4` gives a 1-byte instruction (ALU group 0x42–0x4F). Every other opcode is 2 bytes: loads, stores, and branches 0x20–0x28.
- Unknown opcodes are treated as 2-byte and passed through unchanged.
- State machine with four states. `fetch_ptr` is the register driving `rom_address`.
  - ISSUE: `fetch_ptr = pc`. At the next edge, `fetch_ptr <= pc+1` and the state goes to CAPT_OP.
  - CAPT_OP: the opcode byte is on `rom_data`. At the edge, the opcode is latched. For a 1-byte instruction, go to HOLD. For a 2-byte instruction, go to CAPT_OPR (the ROM samples pc+1 at this same edge).
  - CAPT_OPR: the operand is on `rom_data`. At the edge, the operand is latched and the state goes to HOLD.
  - HOLD: `instr_valid = 1` and outputs are held stable. When `instr_ready=1`, set `pc <= pc + (instr_len2 ? 2 : 1)` and `fetch_ptr` to the same value, then go to ISSUE.
- Address arithmetic: 8-bit add, then mask to `ROM_DEPTH-1`. With 128 words, 8'h7F+1 becomes 8'h00 and 8'h7F+2 becomes 8'h01.
- Branch: `branch_take=1` in any state has the highest priority. At that edge, `pc` and `fetch_ptr` load `branch_target & (ROM_DEPTH-1)`, any partially fetched instruction is discarded, and the state goes to ISSUE.
- Branch and accept together: when `instr_ready` and `branch_take` are high in the same HOLD cycle, the instruction counts as consumed and the next PC is the branch target.
- Outside HOLD, `instr_ready` is ignored.

## Timing
- Reset values:
  - `rom_address`, `pc`, `fetch_ptr` = `RESET_PC`.
  - `instr_valid` = 0.
  - `instr_opcode`, `instr_operand`, `instr_pc` = 8'h00.
  - `instr_len2` = 0, `stall_cycles` = 0.
  - State = ISSUE.
- Reset mid-fetch discards all in-flight state. `reset` has priority over `branch_take`.
- Latency from ISSUE entry to `instr_valid`:
  - 1-byte instruction: 2 cycles, so throughput is 1 instruction per 3 cycles with `instr_ready` held high.
  - 2-byte instruction: 3 cycles, so throughput is 1 instruction per 4 cycles.
- `instr_valid` drops in the cycle after acceptance or a branch.
- All outputs are registered. There is no combinational path from any input to any output.
- Handshake: once `instr_valid` rises, all `instr_*` fields stay constant until the accept edge or a branch.

## Configuration
- `IFU_PERF_CNT_EN`:
  - Defined: `stall_cycles` increments in every cycle with `instr_valid && !instr_ready && !branch_take`. It saturates at 16'hFFFF and clears only on reset.
  - Undefined: the counter logic is removed and `stall_cycles` is tied to 16'h0000. The port list is unchanged.

## Test plan
- Program ROM[0..5] = 86 AA 96 E0 20 00 and hold `instr_ready=1`. Required output sequence: {86,AA,pc 00}, {96,E0,pc 02}, {20,00,pc 04}. `instr_valid` rises 3 cycles after each ISSUE.
- Put a 1-byte op at ROM[0]=42 and ROM[1]=46. Required: `instr_len2=0`, `instr_operand=00`, `instr_pc` values 00 then 01, each valid 2 cycles after ISSUE.
- Hold `instr_ready=0` for 10 cycles while the first instruction is presented. Required: outputs stable, `stall_cycles=10` with the macro defined, 0 without.
- Assert `branch_take` with target 0x04 during CAPT_OPR of the instruction at 0x00. Required: that instruction is never presented, and the next valid has `instr_pc=04`, `opcode=20`.
- Wrap: start with PC=0x7F holding a 2-byte op. Required: the operand is read from 0x00 and the next `instr_pc` is 0x01. Separately, `branch_target`=0x85 gives `instr_pc` 0x05.
- Assert `reset` in HOLD with `instr_ready=1` and `branch_take=1` on the same edge. Required: the next cycle shows all reset values, and the first instruction re-fetched is from `RESET_PC`.
